exe_multicycle: RTL and testbench

EXE_MULTICYCLE -- requirements
Module: exe_multicycle

---
 rtl/exe_multicycle.sv | 223 ++++++++++++++++++++++
 tb/tb_exe_multicycle.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_multicycle.sv
// Execute stage: single-cycle ALU plus an iterative multiply/divide unit that
// writes the architectural HI/LO pair and reports completion with a result beat.
module exe_multicycle #(
  parameter int W       = 32,
  parameter int MUL_LAT = 4
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_op,
  input  logic [W-1:0]         in_a,
  input  logic [W-1:0]         in_b,
  input  logic [$clog2(W)-1:0] in_shamt,
  input  logic [4:0]           in_wreg,
  input  logic                 in_regwrite,
  input  logic [1:0]           fwd_sel_a,
  input  logic [1:0]           fwd_sel_b,
  input  logic [3*W-1:0]       fwd_data,
  output logic                 out_valid,
  input  logic                 out_stall,
  output logic [W-1:0]         out_result,
  output logic [4:0]           out_wreg,
  output logic                 out_regwrite,
  output logic                 busy,
  output logic [W-1:0]         hi_out,
  output logic [W-1:0]         lo_out
);

  localparam int CW = $clog2(W);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLT   = 4'd5;
  localparam logic [3:0] OP_SLTU  = 4'd6;
  localparam logic [3:0] OP_SLL   = 4'd7;
  localparam logic [3:0] OP_SRL   = 4'd8;
  localparam logic [3:0] OP_SRA   = 4'd9;
  localparam logic [3:0] OP_MULT  = 4'd10;
  localparam logic [3:0] OP_MULTU = 4'd11;
  localparam logic [3:0] OP_DIV   = 4'd12;
  localparam logic [3:0] OP_DIVU  = 4'd13;
  localparam logic [3:0] OP_MFHI  = 4'd14;
  localparam logic [3:0] OP_MFLO  = 4'd15;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t         state_reg, state_next;
  logic [CW-1:0]  cnt_reg;
  logic [W-1:0]   a_reg, b_reg;
  logic           sgn_reg, mul_reg;
  logic [W-1:0]   quo_reg, rem_reg, dvs_reg;
  logic [W-1:0]   hi_reg, lo_reg;

  logic [W-1:0]   op_a, op_b, alu;
  logic           hold, accept, is_mul, is_div, is_signed_op, done_fire;
  logic [W-1:0]   mag_a, mag_b;
  logic [W:0]     rem_shift;
  logic           div_ge;
  logic [W-1:0]   rem_next;
  logic [2*W-1:0] ext_a, ext_b, prod;
  logic [W-1:0]   hi_new, lo_new;

  function automatic logic [W-1:0] pick(input logic [1:0] sel, input logic [W-1:0] reg_val,
                                        input logic [3*W-1:0] fwd);
    case (sel)
      2'd1:    pick = fwd[0 +: W];
      2'd2:    pick = fwd[W +: W];
      2'd3:    pick = fwd[2*W +: W];
      default: pick = reg_val;
    endcase
  endfunction

  assign op_a = pick(fwd_sel_a, in_a, fwd_data);
  assign op_b = pick(fwd_sel_b, in_b, fwd_data);

  assign hold         = out_valid & out_stall;
  assign in_ready     = (state_reg == IDLE) & ~hold;
  assign accept       = in_valid & in_ready;
  assign is_mul       = (in_op == OP_MULT) | (in_op == OP_MULTU);
  assign is_div       = (in_op == OP_DIV) | (in_op == OP_DIVU);
  assign is_signed_op = (in_op == OP_MULT) | (in_op == OP_DIV);
  assign done_fire    = (state_reg == DONE) & ~hold;
  assign busy         = (state_reg != IDLE);
  assign hi_out       = hi_reg;
  assign lo_out       = lo_reg;

  // Divider works on magnitudes; signs are reapplied when HI/LO are written.
  assign mag_a = (is_signed_op & op_a[W-1]) ? -op_a : op_a;
  assign mag_b = (is_signed_op & op_b[W-1]) ? -op_b : op_b;

  always_comb begin
    alu = '0;
    case (in_op)
      OP_ADD:  alu = op_a + op_b;
      OP_SUB:  alu = op_a - op_b;
      OP_AND:  alu = op_a & op_b;
      OP_OR:   alu = op_a | op_b;
      OP_XOR:  alu = op_a ^ op_b;
      OP_SLT:  alu = {{(W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: alu = {{(W-1){1'b0}}, (op_a < op_b)};
      OP_SLL:  alu = op_b << in_shamt;
      OP_SRL:  alu = op_b >> in_shamt;
      OP_SRA:  alu = $signed(op_b) >>> in_shamt;
      OP_MFHI: alu = hi_reg;
      OP_MFLO: alu = lo_reg;
      default: alu = '0;
    endcase
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  assign rem_shift = {rem_reg, quo_reg[W-1]};
  assign div_ge    = (rem_shift >= {1'b0, dvs_reg});
  assign rem_next  = div_ge ? W'(rem_shift - {1'b0, dvs_reg}) : rem_shift[W-1:0];

  assign ext_a = sgn_reg ? {{W{a_reg[W-1]}}, a_reg} : {{W{1'b0}}, a_reg};
  assign ext_b = sgn_reg ? {{W{b_reg[W-1]}}, b_reg} : {{W{1'b0}}, b_reg};
  assign prod  = ext_a * ext_b;

  always_comb begin
    hi_new = prod[2*W-1:W];
    lo_new = prod[W-1:0];
    if (!mul_reg) begin
      if (b_reg == '0) begin
        lo_new = '1;
        hi_new = a_reg;
      end else begin
        lo_new = (sgn_reg & (a_reg[W-1] ^ b_reg[W-1])) ? -quo_reg : quo_reg;
        hi_new = (sgn_reg & a_reg[W-1]) ? -rem_reg : rem_reg;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept && is_mul)      state_next = MUL;
        else if (accept && is_div) state_next = DIV;
      end
      MUL:     if (cnt_reg == '0) state_next = DONE;
      DIV:     if (cnt_reg == '0) state_next = DONE;
      DONE:    if (!hold)         state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      sgn_reg   <= 1'b0;
      mul_reg   <= 1'b0;
      quo_reg   <= '0;
      rem_reg   <= '0;
      dvs_reg   <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (accept && (is_mul || is_div)) begin
            a_reg   <= op_a;
            b_reg   <= op_b;
            sgn_reg <= is_signed_op;
            mul_reg <= is_mul;
            quo_reg <= mag_a;
            dvs_reg <= mag_b;
            rem_reg <= '0;
            cnt_reg <= is_mul ? CW'(MUL_LAT - 1) : CW'(W - 1);
          end
        end
        MUL: begin
          if (cnt_reg != '0) cnt_reg <= cnt_reg - CW'(1);
        end
        DIV: begin
          rem_reg <= rem_next;
          quo_reg <= {quo_reg[W-2:0], div_ge};
          if (cnt_reg != '0) cnt_reg <= cnt_reg - CW'(1);
        end
        DONE: begin
          if (done_fire) begin
            hi_reg <= hi_new;
            lo_reg <= lo_new;
          end
        end
        default: ;
      endcase
    end
  end

  // Output beat: held under stall, else completion, else a single-cycle result.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      out_valid    <= 1'b0;
      out_regwrite <= 1'b0;
      out_result   <= '0;
      out_wreg     <= '0;
    end else if (!hold) begin
      if (done_fire) begin
        out_valid    <= 1'b1;
        out_regwrite <= 1'b0;
        out_result   <= lo_new;
        out_wreg     <= '0;
      end else if (accept && !is_mul && !is_div) begin
        out_valid    <= 1'b1;
        out_regwrite <= in_regwrite;
        out_result   <= alu;
        out_wreg     <= in_wreg;
      end else begin
        out_valid    <= 1'b0;
        out_regwrite <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_exe_multicycle.sv
// Self-checking bench for exe_multicycle: directed vector table, multi-cycle
// corner sequences and randomized ops against an arithmetic reference model.
module tb_exe_multicycle;
  localparam int W       = 32;
  localparam int MUL_LAT = 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_a, in_b;
  logic [4:0]  in_shamt;
  logic [4:0]  in_wreg;
  logic        in_regwrite;
  logic [1:0]  fwd_sel_a, fwd_sel_b;
  logic [95:0] fwd_data;
  logic        out_valid;
  logic        out_stall;
  logic [31:0] out_result;
  logic [4:0]  out_wreg;
  logic        out_regwrite;
  logic        busy;
  logic [31:0] hi_out, lo_out;

  exe_multicycle #(.W(W), .MUL_LAT(MUL_LAT)) dut (
    .CLK(CLK), .RESET(RESET),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_shamt(in_shamt),
    .in_wreg(in_wreg), .in_regwrite(in_regwrite),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_stall(out_stall), .out_result(out_result),
    .out_wreg(out_wreg), .out_regwrite(out_regwrite),
    .busy(busy), .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  typedef struct {
    logic [3:0]  op;
    logic [1:0]  sa, sb;
    logic [31:0] a, b;
    logic [95:0] fwd;
    logic [4:0]  sh;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, need 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [1:0] sa, sb,
                              input logic [31:0] a, b, input logic [95:0] fwd,
                              input logic [4:0] sh, input logic [31:0] exp);
    vec_t v;
    v.op = op; v.sa = sa; v.sb = sb; v.a = a; v.b = b;
    v.fwd = fwd; v.sh = sh; v.exp = exp;
    return v;
  endfunction

  function automatic logic [31:0] eff(input logic [1:0] sel, input logic [31:0] r,
                                      input logic [95:0] fwd);
    if (sel == 2'd0) return r;
    return fwd[(int'(sel) - 1) * 32 +: 32];
  endfunction

  // Reference for single-cycle ops, from plain integer arithmetic.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, b,
                                          input logic [4:0] sh, input logic [31:0] hi, lo);
    int sa, sb;
    longint p2, v;
    logic [63:0] u;
    sa = a; sb = b;
    p2 = 1;
    for (int i = 0; i < int'(sh); i++) p2 = p2 * 2;
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return (sa < sb) ? 32'd1 : 32'd0;
      4'd6: return (a < b) ? 32'd1 : 32'd0;
      4'd7: begin u = {32'd0, b} * p2; return u[31:0]; end
      4'd8: begin u = {32'd0, b} / p2; return u[31:0]; end
      4'd9: begin
        v = longint'(sb);
        if (v >= 0) v = v / p2;
        else v = -((-v + p2 - 1) / p2);
        return 32'(v);
      end
      4'd14: return hi;
      4'd15: return lo;
      default: return 32'd0;
    endcase
  endfunction

  function automatic void ref_multi(input logic [3:0] op, input logic [31:0] a, b,
                                    output logic [31:0] hi, output logic [31:0] lo);
    int sa, sb;
    longint q, r;
    logic [63:0] pv;
    sa = a; sb = b;
    hi = '0; lo = '0;
    if (op == 4'd10) begin
      pv = longint'(sa) * longint'(sb);
      hi = pv[63:32]; lo = pv[31:0];
    end else if (op == 4'd11) begin
      pv = {32'd0, a} * {32'd0, b};
      hi = pv[63:32]; lo = pv[31:0];
    end else if (b == 32'd0) begin
      lo = 32'hFFFF_FFFF; hi = a;
    end else if (op == 4'd12) begin
      q = longint'(sa) / longint'(sb);
      r = longint'(sa) % longint'(sb);
      lo = 32'(q); hi = 32'(r);
    end else begin
      lo = a / b; hi = a % b;
    end
  endfunction

  task automatic drive(input logic [3:0] op, input logic [31:0] a, b, input logic [4:0] sh,
                       input logic [1:0] sa, sb, input logic [95:0] fwd,
                       input logic [4:0] wreg, input logic rw);
    @(negedge CLK);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_shamt = sh;
    fwd_sel_a = sa; fwd_sel_b = sb; fwd_data = fwd; in_wreg = wreg; in_regwrite = rw;
    check("ready_at_issue", in_ready, 1);
    @(posedge CLK); #1;
    in_valid = 1'b0;
    fwd_data = ~fwd; in_a = ~a; in_b = ~b;
  endtask

  task automatic run_single(input string name, input logic [3:0] op, input logic [31:0] a, b,
                            input logic [4:0] sh, input logic [1:0] sa, sb,
                            input logic [95:0] fwd, input logic [4:0] wreg, input logic rw,
                            input logic [31:0] exp);
    drive(op, a, b, sh, sa, sb, fwd, wreg, rw);
    check({name, "_valid"}, out_valid, 1);
    check({name, "_result"}, out_result, exp);
    check({name, "_regwrite"}, out_regwrite, rw);
    check({name, "_wreg"}, out_wreg, wreg);
    $display("txn %s op=%0d result=0x%08h expect=0x%08h", name, op, out_result, exp);
  endtask

  task automatic run_multi(input string name, input logic [3:0] op, input logic [31:0] a, b,
                           input logic [1:0] sa, sb, input logic [95:0] fwd);
    logic [31:0] eh, el;
    int n;
    ref_multi(op, eff(sa, a, fwd), eff(sb, b, fwd), eh, el);
    drive(op, a, b, 5'd0, sa, sb, fwd, 5'd9, 1'b1);
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(posedge CLK); #1;
    end
    check({name, "_busy_cycles"}, n, (op >= 4'd12) ? (W + 1) : (MUL_LAT + 1));
    check({name, "_beat_valid"}, out_valid, 1);
    check({name, "_beat_regwrite"}, out_regwrite, 0);
    check({name, "_beat_result"}, out_result, el);
    check({name, "_hi"}, hi_out, eh);
    check({name, "_lo"}, lo_out, el);
    model_hi = eh; model_lo = el;
    $display("txn %s op=%0d busy=%0d hi=0x%08h lo=0x%08h", name, op, n, hi_out, lo_out);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "time limit");
  end

  initial begin
    in_valid = 0; in_op = 0; in_a = 0; in_b = 0; in_shamt = 0; in_wreg = 0;
    in_regwrite = 0; fwd_sel_a = 0; fwd_sel_b = 0; fwd_data = 0; out_stall = 0;

    vecs[0]  = mk(4'd0, 2'd2, 2'd0, 32'h0000DEAD, 32'h3, {32'h0, 32'h5, 32'h0}, 5'd0, 32'h8);
    vecs[1]  = mk(4'd1, 2'd0, 2'd0, 32'h0, 32'h1, 96'h0, 5'd0, 32'hFFFF_FFFF);
    vecs[2]  = mk(4'd2, 2'd0, 2'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 96'h0, 5'd0, 32'hF000_F000);
    vecs[3]  = mk(4'd3, 2'd0, 2'd0, 32'hF0F0_F0F0, 32'h0F0F_0000, 96'h0, 5'd0, 32'hFFFF_F0F0);
    vecs[4]  = mk(4'd4, 2'd0, 2'd0, 32'hFFFF_0000, 32'h0F0F_0F0F, 96'h0, 5'd0, 32'hF0F0_0F0F);
    vecs[5]  = mk(4'd5, 2'd0, 2'd0, 32'hFFFF_FFFF, 32'h1, 96'h0, 5'd0, 32'h1);
    vecs[6]  = mk(4'd6, 2'd0, 2'd0, 32'hFFFF_FFFF, 32'h1, 96'h0, 5'd0, 32'h0);
    vecs[7]  = mk(4'd7, 2'd0, 2'd0, 32'h0, 32'h1, 96'h0, 5'd31, 32'h8000_0000);
    vecs[8]  = mk(4'd8, 2'd0, 2'd0, 32'h0, 32'h8000_0000, 96'h0, 5'd4, 32'h0800_0000);
    vecs[9]  = mk(4'd9, 2'd0, 2'd0, 32'h0, 32'h8000_0000, 96'h0, 5'd4, 32'hF800_0000);
    vecs[10] = mk(4'd0, 2'd1, 2'd3, 32'h1, 32'h2, {32'h7FFF_FFFF, 32'h0, 32'h10}, 5'd0, 32'h8000_000F);
    vecs[11] = mk(4'd0, 2'd0, 2'd0, 32'hFFFF_FFFF, 32'h1, 96'h0, 5'd0, 32'h0);

    // Reset state, sampled while RESET is still low.
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_wreg", out_wreg, 0);
    check("rst_out_regwrite", out_regwrite, 0);
    check("rst_busy", busy, 0);
    check("rst_hi", hi_out, 0);
    check("rst_lo", lo_out, 0);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_single($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh,
                 vecs[i].sa, vecs[i].sb, vecs[i].fwd, 5'(i + 1), 1'(i % 2 == 0), vecs[i].exp);
    end

    run_multi("mult_neg", 4'd10, 32'hFFFF_FFFE, 32'h3, 2'd0, 2'd0, 96'h0);
    check("mult_neg_hi_const", hi_out, 32'hFFFF_FFFF);
    check("mult_neg_lo_const", lo_out, 32'hFFFF_FFFA);
    run_single("mflo", 4'd15, 32'h0, 32'h0, 5'd0, 2'd0, 2'd0, 96'h0, 5'd2, 1'b1, 32'hFFFF_FFFA);
    run_single("mfhi", 4'd14, 32'h0, 32'h0, 5'd3, 2'd0, 2'd0, 96'h0, 5'd3, 1'b1, 32'hFFFF_FFFF);
    run_multi("div_neg", 4'd12, 32'hFFFF_FFF9, 32'h2, 2'd0, 2'd0, 96'h0);
    check("div_neg_lo_const", lo_out, 32'hFFFF_FFFD);
    check("div_neg_hi_const", hi_out, 32'hFFFF_FFFF);
    run_multi("divu_zero", 4'd13, 32'h12, 32'h0, 2'd0, 2'd0, 96'h0);
    check("divu_zero_lo_const", lo_out, 32'hFFFF_FFFF);
    check("divu_zero_hi_const", hi_out, 32'h0000_0012);

    // Stall on a single-cycle result with another op pending.
    drive(4'd0, 32'h1, 32'h2, 5'd0, 2'd0, 2'd0, 96'h0, 5'd4, 1'b1);
    check("st_first", out_result, 32'h3);
    out_stall = 1'b1;
    in_valid = 1'b1; in_op = 4'd1; in_a = 32'd10; in_b = 32'd4;
    fwd_sel_a = 2'd0; fwd_sel_b = 2'd0; in_wreg = 5'd5; in_regwrite = 1'b1;
    #1 check("st_ready_low", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      check("st_hold_valid", out_valid, 1);
      check("st_hold_result", out_result, 32'h3);
      check("st_hold_wreg", out_wreg, 5'd4);
      check("st_hold_ready", in_ready, 0);
    end
    out_stall = 1'b0;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    check("st_release_result", out_result, 32'h6);
    check("st_release_wreg", out_wreg, 5'd5);
    $display("txn stall_single result=0x%08h", out_result);

    // Stall on a completion beat.
    run_multi("stall_mul", 4'd11, 32'h8000_0001, 32'h4, 2'd0, 2'd0, 96'h0);
    out_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      check("stb_valid", out_valid, 1);
      check("stb_result", out_result, 32'h4);
      check("stb_regwrite", out_regwrite, 0);
      check("stb_ready", in_ready, 0);
    end
    out_stall = 1'b0;
    @(posedge CLK); #1;
    check("stb_release_valid", out_valid, 0);
    $display("txn stall_beat hi=0x%08h lo=0x%08h", hi_out, lo_out);

    // Reset in the middle of a divide.
    drive(4'd12, 32'd100, 32'd7, 5'd0, 2'd0, 2'd0, 96'h0, 5'd1, 1'b1);
    repeat (10) @(posedge CLK);
    #1 check("rd_busy_before", busy, 1);
    #2 RESET = 1'b0;
    #1;
    check("rd_out_valid", out_valid, 0);
    check("rd_out_result", out_result, 0);
    check("rd_out_wreg", out_wreg, 0);
    check("rd_out_regwrite", out_regwrite, 0);
    check("rd_busy", busy, 0);
    check("rd_hi", hi_out, 0);
    check("rd_lo", lo_out, 0);
    model_hi = '0; model_lo = '0;
    in_valid = 1'b1; in_op = 4'd0; in_a = 32'd20; in_b = 32'd22;
    fwd_sel_a = 2'd0; fwd_sel_b = 2'd0; in_wreg = 5'd11; in_regwrite = 1'b1;
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    check("rd_add_valid", out_valid, 1);
    check("rd_add_result", out_result, 32'd42);
    check("rd_add_regwrite", out_regwrite, 1);
    check("rd_hi_after", hi_out, 0);
    $display("txn reset_add result=0x%08h", out_result);

    for (int t = 0; t < 40; t++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      logic [4:0]  sh, wr;
      logic [1:0]  sa, sb;
      logic [95:0] fwd;
      logic        rw;
      op  = 4'($urandom_range(0, 15));
      a   = $urandom;
      b   = $urandom;
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      else if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
      sh  = 5'($urandom_range(0, 31));
      sa  = 2'($urandom_range(0, 3));
      sb  = 2'($urandom_range(0, 3));
      fwd = {$urandom, $urandom, $urandom};
      if ($urandom_range(0, 5) == 0) fwd[31:0] = 32'd0;
      rw  = 1'($urandom_range(0, 1));
      wr  = 5'($urandom_range(0, 31));
      if (op >= 4'd10 && op <= 4'd13)
        run_multi("rand_multi", op, a, b, sa, sb, fwd);
      else
        run_single("rand_single", op, a, b, sh, sa, sb, fwd, wr, rw,
                   ref_alu(op, eff(sa, a, fwd), eff(sb, b, fwd), sh, model_hi, model_lo));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
